// File: rtl/alu_pipe.sv
// alu_pipe: registered ALU with a valid/ready handshake on each side.
// Produces a registered result plus a status word {C,N,V,Z} and an
// illegal-op flag. Single-cycle ops complete in one cycle.
// Optional feature macro: ALU_MUL_EN builds op 11 (MUL) as an iterative
// shift-add multiplier with WIDTH+1 cycles of latency. Without the macro,
// op 11 decodes as illegal.
//
// Handshake: a request is accepted on a rising clk edge where
// in_valid && in_ready. A result is consumed on a rising clk edge where
// out_valid && out_ready. result/status/illegal stay stable while
// out_valid=1 and out_ready=0.
module alu_pipe #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       status,
  output logic             illegal
);

  // Shift amount width, derived from WIDTH.
  localparam int SHW = $clog2(WIDTH);

`ifdef ALU_MUL_EN
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, DONE = 2'd2} state_t;
`endif

  // Current FSM state; kept as a named signal so checkers can bind to it.
  state_t state;
  state_t state_next;

  logic accept;
  logic is_mul;

  // Single-cycle datapath signals.
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum;
  logic [SHW-1:0]   shamt;
  logic             is_sub;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c;
  logic             alu_v;
  logic             alu_ill;
  logic [3:0]       alu_stat;

`ifdef ALU_MUL_EN
  // Iterative multiplier: after WIDTH steps acc holds the low WIDTH bits.
  localparam logic [SHW:0] CNT_LAST = WIDTH[SHW:0];
  logic [WIDTH-1:0] ma;
  logic [WIDTH-1:0] mb;
  logic [WIDTH-1:0] acc;
  logic [SHW:0]     cnt;
  logic             mul_last;
  assign is_mul   = (op == 4'd11);
  assign mul_last = (cnt == CNT_LAST);
`else
  assign is_mul = 1'b0;
`endif

  // Combinational single-cycle ALU; SUB reuses the adder as a + ~b + 1.
  always_comb begin
    is_sub  = (op == 4'd1);
    b_eff   = is_sub ? ~b_in : b_in;
    sum     = {1'b0, a_in} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};
    shamt   = b_in[SHW-1:0];
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_ill = 1'b0;
    case (op)
      4'd0, 4'd1: begin
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        // Overflow when both adder inputs share a sign the sum does not.
        alu_v   = (a_in[WIDTH-1] == b_eff[WIDTH-1]) &&
                  (sum[WIDTH-1] != a_in[WIDTH-1]);
      end
      4'd2:  alu_res = a_in & b_in;
      4'd3:  alu_res = a_in | b_in;
      4'd4:  alu_res = ~a_in;
      4'd5:  alu_res = a_in ^ b_in;
      4'd6:  alu_res = a_in << shamt;
      4'd7:  alu_res = a_in >> shamt;
      4'd8:  alu_res = WIDTH'($signed(a_in) >>> shamt);
      4'd9:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a_in) < $signed(b_in))};
      4'd10: alu_res = {{(WIDTH-1){1'b0}}, (a_in < b_in)};
      default: alu_ill = 1'b1;
    endcase
    alu_stat = {alu_c, alu_res[WIDTH-1], alu_v, (alu_res == '0)};
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    case (state)
      IDLE: in_ready = 1'b1;
      DONE: in_ready = out_ready;
      default: in_ready = 1'b0;
    endcase
    accept = in_valid && in_ready;
    case (state)
      IDLE: begin
        if (accept) begin
`ifdef ALU_MUL_EN
          state_next = is_mul ? BUSY : DONE;
`else
          state_next = DONE;
`endif
        end
      end
`ifdef ALU_MUL_EN
      BUSY: begin
        if (mul_last) state_next = DONE;
      end
`endif
      DONE: begin
        if (out_ready) begin
          if (accept) begin
`ifdef ALU_MUL_EN
            state_next = is_mul ? BUSY : DONE;
`else
            state_next = DONE;
`endif
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign out_valid = (state == DONE);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Output registers and multiplier datapath.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      result  <= '0;
      status  <= 4'b0000;
      illegal <= 1'b0;
`ifdef ALU_MUL_EN
      ma  <= '0;
      mb  <= '0;
      acc <= '0;
      cnt <= '0;
`endif
    end else begin
      if (accept && !is_mul) begin
        result  <= alu_res;
        status  <= alu_stat;
        illegal <= alu_ill;
      end
`ifdef ALU_MUL_EN
      else if (accept && is_mul) begin
        ma  <= a_in;
        mb  <= b_in;
        acc <= '0;
        cnt <= '0;
      end else if (state == BUSY) begin
        if (mul_last) begin
          // Extra cycle after the last step moves acc to the output.
          result  <= acc;
          status  <= {1'b0, acc[WIDTH-1], 1'b0, (acc == '0)};
          illegal <= 1'b0;
        end else begin
          if (mb[0]) acc <= acc + ma;
          ma  <= ma << 1;
          mb  <= mb >> 1;
          cnt <= cnt + 1'b1;
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Directed testbench for alu_pipe (WIDTH=32).
module tb_alu_pipe;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  op;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic [3:0]  status;
  logic        illegal;

  int vectors;
  int errors;

  typedef struct {
    string      name;
    logic [3:0] op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic [3:0] st;
    logic       ill;
  } vec_t;

  vec_t vecs[$];

  alu_pipe #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a_in      (a_in),
    .b_in      (b_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .status    (status),
    .illegal   (illegal)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver: present one request for one edge, then drop in_valid.
  task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    in_valid = 1'b1;
    op       = o;
    a_in     = a;
    b_in     = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic add_vec(input string n, input logic [3:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] r,
                         input logic [3:0] st, input logic ill);
    vec_t v;
    v.name = n; v.op = o; v.a = a; v.b = b; v.r = r; v.st = st; v.ill = ill;
    vecs.push_back(v);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    vectors++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_out_valid got %b expected 0", out_valid);
    end
    vectors++;
    if (result !== 32'h0) begin
      errors++; $display("FAIL reset_result got %h expected 00000000", result);
    end
    vectors++;
    if (status !== 4'b0000) begin
      errors++; $display("FAIL reset_status got %b expected 0000", status);
    end
    vectors++;
    if (illegal !== 1'b0) begin
      errors++; $display("FAIL reset_illegal got %b expected 0", illegal);
    end
    vectors++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready got %b expected 1", in_ready);
    end
  endtask

  // Single-cycle ops from a hand-computed table; status is {C,N,V,Z}.
  task automatic test_ops;
    add_vec("add_ovf",  4'd0,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 4'b0110, 1'b0);
    add_vec("add_wrap", 4'd0,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 4'b1001, 1'b0);
    add_vec("sub_zero", 4'd1,  32'h00000005, 32'h00000005, 32'h00000000, 4'b1001, 1'b0);
    add_vec("sub_neg",  4'd1,  32'h00000000, 32'h00000001, 32'hFFFFFFFF, 4'b0100, 1'b0);
    add_vec("and",      4'd2,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 4'b0100, 1'b0);
    add_vec("or",       4'd3,  32'h0F0F0000, 32'h00F0000F, 32'h0FFF000F, 4'b0000, 1'b0);
    add_vec("not",      4'd4,  32'h00000000, 32'h12345678, 32'hFFFFFFFF, 4'b0100, 1'b0);
    add_vec("xor",      4'd5,  32'hAAAAAAAA, 32'hAAAAAAAA, 32'h00000000, 4'b0001, 1'b0);
    add_vec("sll",      4'd6,  32'h00000001, 32'h0000001F, 32'h80000000, 4'b0100, 1'b0);
    add_vec("srl",      4'd7,  32'h80000000, 32'h00000004, 32'h08000000, 4'b0000, 1'b0);
    add_vec("sra",      4'd8,  32'h80000000, 32'h00000024, 32'hF8000000, 4'b0100, 1'b0);
    add_vec("slt",      4'd9,  32'hFFFFFFFF, 32'h00000001, 32'h00000001, 4'b0000, 1'b0);
    add_vec("sltu",     4'd10, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 4'b0001, 1'b0);
    add_vec("op13",     4'd13, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 4'b0001, 1'b1);
    add_vec("op15",     4'd15, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 4'b0001, 1'b1);
`ifndef ALU_MUL_EN
    add_vec("op11_nomul", 4'd11, 32'h0000FFFF, 32'h00010001, 32'h00000000, 4'b0001, 1'b1);
`endif
    foreach (vecs[i]) begin
      vectors++;
      if (in_ready !== 1'b1) begin
        errors++; $display("FAIL %s in_ready got %b expected 1", vecs[i].name, in_ready);
      end
      issue(vecs[i].op, vecs[i].a, vecs[i].b);
      vectors++;
      if (out_valid !== 1'b1) begin
        errors++; $display("FAIL %s out_valid got %b expected 1", vecs[i].name, out_valid);
      end
      vectors++;
      if (result !== vecs[i].r) begin
        errors++; $display("FAIL %s result got %h expected %h", vecs[i].name, result, vecs[i].r);
      end
      vectors++;
      if (status !== vecs[i].st) begin
        errors++; $display("FAIL %s status got %b expected %b", vecs[i].name, status, vecs[i].st);
      end
      vectors++;
      if (illegal !== vecs[i].ill) begin
        errors++; $display("FAIL %s illegal got %b expected %b", vecs[i].name, illegal, vecs[i].ill);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      vectors++;
      if (out_valid !== 1'b0) begin
        errors++; $display("FAIL %s out_valid_after got %b expected 0", vecs[i].name, out_valid);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] ba[4];
    logic [31:0] bb[4];
    logic [31:0] br[4];
    ba[0] = 32'h00000001; bb[0] = 32'h00000002; br[0] = 32'h00000003;
    ba[1] = 32'h0000000A; bb[1] = 32'h00000014; br[1] = 32'h0000001E;
    ba[2] = 32'hFFFFFFFF; bb[2] = 32'hFFFFFFFF; br[2] = 32'hFFFFFFFE;
    ba[3] = 32'h12345678; bb[3] = 32'h11111111; br[3] = 32'h23456789;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      op       = 4'd0;
      a_in     = ba[i];
      b_in     = bb[i];
      vectors++;
      if (in_ready !== 1'b1) begin
        errors++; $display("FAIL b2b_in_ready[%0d] got %b expected 1", i, in_ready);
      end
      @(posedge clk);
      #1;
      vectors++;
      if (out_valid !== 1'b1 || result !== br[i]) begin
        errors++;
        $display("FAIL b2b_result[%0d] got valid=%b %h expected valid=1 %h", i, out_valid, result, br[i]);
      end
    end
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    vectors++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL b2b_drain out_valid got %b expected 0", out_valid);
    end
  endtask

  task automatic test_stall;
    issue(4'd0, 32'h00000003, 32'h00000004);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      op       = 4'd1;
      a_in     = 32'h00000064;
      b_in     = 32'h00000001;
      vectors++;
      if (in_ready !== 1'b0) begin
        errors++; $display("FAIL stall_in_ready[%0d] got %b expected 0", i, in_ready);
      end
      @(posedge clk);
      #1;
      vectors++;
      if (out_valid !== 1'b1 || result !== 32'h00000007) begin
        errors++;
        $display("FAIL stall_hold[%0d] got valid=%b %h expected valid=1 00000007", i, out_valid, result);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL stall_release got valid=%b ready=%b expected valid=0 ready=1", out_valid, in_ready);
    end
  endtask

`ifdef ALU_MUL_EN
  task automatic test_mul;
    int cyc;
    int busy_ready;
    cyc = 0;
    busy_ready = 0;
    issue(4'd11, 32'h0000FFFF, 32'h00010001);
    while (out_valid !== 1'b1 && cyc < 100) begin
      if (in_ready !== 1'b0) busy_ready++;
      // Operand changes while busy must not disturb the product.
      in_valid = 1'b1;
      op   = 4'd11;
      a_in = 32'hDEADBEEF;
      b_in = 32'h00000003;
      @(posedge clk);
      #1;
      cyc++;
    end
    in_valid = 1'b0;
    vectors++;
    if (cyc !== 33) begin
      errors++; $display("FAIL mul_latency got %0d expected 33", cyc);
    end
    vectors++;
    if (busy_ready !== 0) begin
      errors++; $display("FAIL mul_busy_in_ready got %0d cycles high expected 0", busy_ready);
    end
    vectors++;
    if (result !== 32'hFFFFFFFF) begin
      errors++; $display("FAIL mul_result got %h expected ffffffff", result);
    end
    vectors++;
    if (status !== 4'b0100 || illegal !== 1'b0) begin
      errors++; $display("FAIL mul_status got %b ill=%b expected 0100 ill=0", status, illegal);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_mul_reset;
    int seen;
    seen = 0;
    issue(4'd11, 32'h00000007, 32'h00000006);
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== 32'h0) begin
      errors++;
      $display("FAIL mul_reset got valid=%b ready=%b %h expected valid=0 ready=1 00000000",
               out_valid, in_ready, result);
    end
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (out_valid !== 1'b0) seen++;
    end
    vectors++;
    if (seen !== 0) begin
      errors++; $display("FAIL mul_reset_no_output got %0d valid cycles expected 0", seen);
    end
  endtask
`endif

  initial begin
    vectors   = 0;
    errors    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    op        = 4'd0;
    a_in      = 32'h0;
    b_in      = 32'h0;
    test_reset();
    test_ops();
    test_back_to_back();
    test_stall();
`ifdef ALU_MUL_EN
    test_mul();
    test_mul_reset();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
